wdt_ctrl: RTL and testbench
===========================

WDT_CTRL -- requirements
Module: wdt_ctrl

Interface
REQ-001 Parameter SETTLE, default 4: cycles WTOCNT is held stable with WDEN low before WDEN rises, and after WDEN falls.
REQ-002 Parameter LIVE_HOLD, default 4: cycles WDLIVE is held high per kick, so the slower WDT clock samples it.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 wr_en  in  1  register write strobe.
REQ-006 rd_en  in  1  register read strobe.
REQ-007 addr  in  2  register select: 0=CTRL, 1=TOCNT, 2=KICK, 3=STATUS.
REQ-008 wdata  in  32  write data.
REQ-009 rdata  out  32  read data, registered.
REQ-010 wto_in  in  1  WDT timeout, asynchronous to clk.
REQ-011 WDEN  out  1  WDT enable, registered.
REQ-012 WDLIVE  out  1  WDT kick, registered.
REQ-013 WTOCNT  out  32  WDT timeout count, registered.
REQ-014 irq  out  1  timeout interrupt, level.
REQ-015 rst_req  out  1  system reset request, sticky.
REQ-016 busy  out  1  high in LOAD, KICK and STOP.

Function
REQ-017 FSM states: IDLE, LOAD, RUN, KICK, STOP; 3-bit encoding.
REQ-018 IDLE: CTRL write with wdata[0]=1 -> LOAD; WDEN=0.
REQ-019 LOAD: WDEN=0 for SETTLE cycles, then -> RUN; WDEN=1 from the first RUN cycle.
REQ-020 RUN: KICK write -> KICK; CTRL write with wdata[0]=0 -> STOP.
REQ-021 KICK: WDLIVE=1 and WDEN=1 for exactly LIVE_HOLD cycles, then -> RUN with WDLIVE=0.
REQ-022 STOP: WDEN=0 for SETTLE cycles, then -> IDLE.
REQ-023 TOCNT write is accepted only in IDLE; WTOCNT is updated on the next cycle and never changes while WDEN=1.
REQ-024 Any write not accepted by REQ-018..REQ-023 is ignored and sets sticky STATUS.err. This covers writes while busy, TOCNT outside IDLE, KICK outside RUN, and a CTRL value equal to the current enable state.
REQ-025 wto_in passes through a 2-flop synchronizer and a rising-edge detector; a rising edge reaches the strike logic 3 cycles after it is stable at the pin.
REQ-026 A wto edge in RUN or KICK sets irq and increments the 2-bit strike counter, saturating at 2.
REQ-027 When strike reaches 2, rst_req is set and held until rst.
REQ-028 An accepted KICK clears strike to 0 and leaves irq unchanged.
REQ-029 A wto edge and an accepted KICK in the same cycle: the KICK wins, strike becomes 0, and irq is set.
REQ-030 wto edges in IDLE, LOAD or STOP are ignored.
REQ-031 STATUS write is write-1-to-clear: wdata[0] clears irq, wdata[2] clears err; it is accepted in every state.
REQ-032 STATUS read layout: [0] irq, [1] rst_req, [2] err, [3] busy, [6:4] state, [9:8] strike; all other bits 0.
REQ-033 rdata is valid one cycle after rd_en; CTRL reads {31'b0, enable}, TOCNT reads WTOCNT, KICK reads 0.
REQ-034 A read and a write in the same cycle: rdata returns the pre-write value.

Reset
REQ-035 On rst: state=IDLE; WDEN=0, WDLIVE=0, WTOCNT=0, irq=0, rst_req=0, busy=0, rdata=0; strike, err and synchronizer flops all 0.
REQ-036 rst asserted mid-operation (including in KICK) drops WDEN and WDLIVE on the next clk edge.

Structure
REQ-037 Package wdt_ctrl_pkg holds the state enum, the register address constants and the STATUS bit positions.
REQ-038 Sub-module wdt_sync implements the 2-flop synchronizer plus rising-edge detector for wto_in.

Verification
REQ-039 Write TOCNT=100, then CTRL=1 -> WTOCNT=100 next cycle; WDEN rises exactly 4 cycles after LOAD entry; busy is high for those 4 cycles.
REQ-040 In RUN, write KICK -> WDLIVE high for exactly 4 cycles; busy=1; a second KICK during this window sets err and does not extend WDLIVE.
REQ-041 In RUN, pulse wto_in twice with no kick -> irq=1 after the first edge, strike=2 and rst_req=1 after the second; rst_req stays high until rst.
REQ-042 wto edge arriving at the strike logic in the same cycle as an accepted KICK -> strike=0, irq=1; STATUS write 0x1 -> irq=0.
REQ-043 Write TOCNT=5 while in RUN -> WTOCNT unchanged, err=1; STATUS write 0x4 -> err=0.
REQ-044 Assert rst during KICK -> the next cycle has WDEN=0, WDLIVE=0, state=IDLE, and STATUS reads 0.

Source files
------------

// File: rtl/wdt_ctrl_pkg.sv
// wdt_ctrl_pkg: shared states, register map and STATUS layout for the watchdog controller.
package wdt_ctrl_pkg;
   typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, KICK = 3'd3, STOP = 3'd4} state_t;
   localparam logic [1:0] A_CTRL = 2'd0, A_TOCNT = 2'd1, A_KICK = 2'd2, A_STATUS = 2'd3;
   localparam int ST_IRQ = 0, ST_RST_REQ = 1, ST_ERR = 2, ST_BUSY = 3, ST_STATE = 4, ST_STRIKE = 8;
endpackage

// File: rtl/wdt_ctrl_if.sv
// wdt_ctrl_if: register bus between host and watchdog controller.
interface wdt_ctrl_if;
   logic        wr_en;
   logic        rd_en;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   modport master (output wr_en, rd_en, addr, wdata, input rdata);
   modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/wdt_sync.sv
// wdt_sync: 2-flop synchronizer plus rising-edge detector for the asynchronous timeout pin.
module wdt_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);
   logic [2:0] sr;
   always_ff @(posedge clk)
      sr <= rst ? 3'b000 : {sr[1:0], d};
   assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/wdt_ctrl.sv
// wdt_ctrl: register-driven watchdog enable/kick sequencer with timeout strike and reset request.
module wdt_ctrl
   import wdt_ctrl_pkg::*;
#(
   parameter int SETTLE    = 4,
   parameter int LIVE_HOLD = 4
) (
   input  logic        clk,
   input  logic        rst,
   wdt_ctrl_if.slave   bus,
   input  logic        wto_in,
   output logic        WDEN,
   output logic        WDLIVE,
   output logic [31:0] WTOCNT,
   output logic        irq,
   output logic        rst_req,
   output logic        busy
);
   state_t      state, state_n;
   logic [15:0] cnt;
   logic [1:0]  strike, strike_n;
   logic        err, wto_edge, run_like;
   logic        wr_ctrl, wr_tocnt, wr_kick, wr_status;
   logic        ctrl_on, ctrl_off, tocnt_ok, kick_ok, err_set;
   logic [31:0] status, rdata_q;

   wdt_sync u_sync (.clk(clk), .rst(rst), .d(wto_in), .rise(wto_edge));

   assign wr_ctrl   = bus.wr_en && bus.addr == A_CTRL;
   assign wr_tocnt  = bus.wr_en && bus.addr == A_TOCNT;
   assign wr_kick   = bus.wr_en && bus.addr == A_KICK;
   assign wr_status = bus.wr_en && bus.addr == A_STATUS;
   assign ctrl_on   = wr_ctrl && bus.wdata[0] && state == IDLE;
   assign ctrl_off  = wr_ctrl && !bus.wdata[0] && state == RUN;
   assign tocnt_ok  = wr_tocnt && state == IDLE;
   assign kick_ok   = wr_kick && state == RUN;
   assign err_set   = (wr_ctrl && !ctrl_on && !ctrl_off) || (wr_tocnt && !tocnt_ok) || (wr_kick && !kick_ok);
   assign run_like  = state == RUN || state == KICK;
   assign busy      = state == LOAD || state == KICK || state == STOP;

   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= (state_n == state) ? cnt + 16'd1 : 16'd0;
      end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: state_n = ctrl_on ? LOAD : IDLE;
         LOAD: state_n = (cnt == 16'(SETTLE - 1)) ? RUN : LOAD;
         RUN:  state_n = kick_ok ? KICK : ctrl_off ? STOP : RUN;
         KICK: state_n = (cnt == 16'(LIVE_HOLD - 1)) ? RUN : KICK;
         STOP: state_n = (cnt == 16'(SETTLE - 1)) ? IDLE : STOP;
         default: state_n = IDLE;
      endcase
   end

   // an accepted kick beats a simultaneous timeout edge
   assign strike_n = kick_ok ? 2'd0 : (wto_edge && run_like && strike != 2'd2) ? strike + 2'd1 : strike;

   always_comb begin
      status                      = '0;
      status[ST_IRQ]              = irq;
      status[ST_RST_REQ]          = rst_req;
      status[ST_ERR]              = err;
      status[ST_BUSY]             = busy;
      status[ST_STATE +: 3]       = state;
      status[ST_STRIKE +: 2]      = strike;
   end

   always_ff @(posedge clk)
      if (rst) begin
         WDEN    <= 1'b0;
         WDLIVE  <= 1'b0;
         WTOCNT  <= '0;
         irq     <= 1'b0;
         rst_req <= 1'b0;
         err     <= 1'b0;
         strike  <= 2'd0;
         rdata_q <= '0;
      end else begin
         WDEN    <= state_n == RUN || state_n == KICK;
         WDLIVE  <= state_n == KICK;
         if (tocnt_ok) WTOCNT <= bus.wdata;
         irq     <= (wto_edge && run_like) || (irq && !(wr_status && bus.wdata[0]));
         err     <= err_set || (err && !(wr_status && bus.wdata[2]));
         strike  <= strike_n;
         rst_req <= rst_req || strike_n == 2'd2;
         if (bus.rd_en)
            rdata_q <= bus.addr == A_CTRL ? {31'b0, WDEN} : bus.addr == A_TOCNT ? WTOCNT :
                       bus.addr == A_STATUS ? status : 32'd0;
      end

   assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_wdt_ctrl.sv
// tb_wdt_ctrl: directed and randomized stimulus, reference model feeding a scoreboard checked every cycle.
module tb_wdt_ctrl;
   import wdt_ctrl_pkg::*;
   localparam int SETTLE = 4, LIVE_HOLD = 4;

   logic        clk = 1'b0, rst = 1'b1, wto_in = 1'b0;
   logic        WDEN, WDLIVE, irq, rst_req, busy;
   logic [31:0] WTOCNT;
   wdt_ctrl_if bus();

   wdt_ctrl #(.SETTLE(SETTLE), .LIVE_HOLD(LIVE_HOLD)) dut (
      .clk(clk), .rst(rst), .bus(bus), .wto_in(wto_in), .WDEN(WDEN), .WDLIVE(WDLIVE),
      .WTOCNT(WTOCNT), .irq(irq), .rst_req(rst_req), .busy(busy));

   always #5 clk = ~clk;

   typedef struct {logic wden, wdlive, irq, rr, busy; logic [31:0] tocnt;} exp_t;
   exp_t        eq[$];
   logic [31:0] rq[$];
   logic        rd_pend = 1'b0;
   int          checks = 0, passed = 0;

   // reference model: phase with a countdown of remaining cycles, pin history of recent samples
   state_t      ph = IDLE, p0;
   int          tmr, m_irq, m_rr, m_err, m_strike;
   logic [31:0] m_toc, d;
   logic [2:0]  hist;
   logic        ev, kick_ok;
   exp_t        e;

   function automatic int busy_of(state_t s);
      return (s == LOAD || s == KICK || s == STOP) ? 1 : 0;
   endfunction

   always @(posedge clk) begin
      rd_pend = 1'b0;
      if (rst) begin
         ph = IDLE; tmr = 0; m_irq = 0; m_rr = 0; m_err = 0; m_strike = 0; m_toc = '0; hist = '0;
      end else begin
         p0 = ph;
         ev = hist[1] && !hist[2] && (p0 == RUN || p0 == KICK);
         hist = {hist[1:0], wto_in};
         if (bus.rd_en) begin
            rd_pend = 1'b1;
            if (bus.addr == A_CTRL) rq.push_back((p0 == RUN || p0 == KICK) ? 32'd1 : 32'd0);
            else if (bus.addr == A_TOCNT) rq.push_back(m_toc);
            else if (bus.addr == A_KICK) rq.push_back(32'd0);
            else rq.push_back(32'(m_irq + 2 * m_rr + 4 * m_err + 8 * busy_of(p0) + 16 * int'(p0) + 256 * m_strike));
         end
         kick_ok = 1'b0;
         if (p0 == LOAD || p0 == KICK || p0 == STOP) begin
            tmr--;
            if (tmr == 0) ph = (p0 == STOP) ? IDLE : RUN;
         end
         if (bus.wr_en) begin
            d = bus.wdata;
            case (bus.addr)
               A_CTRL: begin
                  if (p0 == IDLE && d[0]) begin ph = LOAD; tmr = SETTLE; end
                  else if (p0 == RUN && !d[0]) begin ph = STOP; tmr = SETTLE; end
                  else m_err = 1;
               end
               A_TOCNT: if (p0 == IDLE) m_toc = d; else m_err = 1;
               A_KICK: begin
                  if (p0 == RUN) begin ph = KICK; tmr = LIVE_HOLD; kick_ok = 1'b1; end
                  else m_err = 1;
               end
               default: begin
                  if (d[0]) m_irq = 0;
                  if (d[2]) m_err = 0;
               end
            endcase
         end
         if (ev) m_irq = 1;
         if (kick_ok) m_strike = 0;
         else if (ev && m_strike < 2) m_strike++;
         if (m_strike == 2) m_rr = 1;
      end
      e.wden   = ph == RUN || ph == KICK;
      e.wdlive = ph == KICK;
      e.busy   = busy_of(ph) == 1;
      e.irq    = m_irq == 1;
      e.rr     = m_rr == 1;
      e.tocnt  = m_toc;
      eq.push_back(e);
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
   endtask

   exp_t ex;
   always @(negedge clk) begin
      if (eq.size() > 0) begin
         ex = eq.pop_front();
         chk("WDEN", 32'(WDEN), 32'(ex.wden));
         chk("WDLIVE", 32'(WDLIVE), 32'(ex.wdlive));
         chk("busy", 32'(busy), 32'(ex.busy));
         chk("irq", 32'(irq), 32'(ex.irq));
         chk("rst_req", 32'(rst_req), 32'(ex.rr));
         chk("WTOCNT", WTOCNT, ex.tocnt);
      end
      if (rd_pend && rq.size() > 0) chk("rdata", bus.rdata, rq.pop_front());
   end

   logic pin = 1'b0, rsv = 1'b1;

   task automatic op(input logic w, input logic r, input logic [1:0] a, input logic [31:0] dat);
      @(negedge clk);
      rst = rsv; wto_in = pin;
      bus.wr_en = w; bus.rd_en = r; bus.addr = a; bus.wdata = dat;
   endtask

   task automatic idle(input int n);
      repeat (n) op(1'b0, 1'b0, A_CTRL, 32'd0);
   endtask

   initial begin
      int r;
      logic [1:0] a;
      logic [31:0] dat;
      bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = A_CTRL; bus.wdata = '0;
      rsv = 1'b1; idle(3); rsv = 1'b0;
      op(1, 0, A_TOCNT, 32'd100); op(1, 0, A_CTRL, 32'd1); idle(6);
      op(0, 1, A_CTRL, 0); op(1, 0, A_KICK, 0); op(1, 1, A_KICK, 0); idle(5);
      op(0, 1, A_STATUS, 0); op(1, 0, A_STATUS, 32'd4);
      pin = 1; idle(4); pin = 0; idle(4); op(0, 1, A_STATUS, 0);
      pin = 1; idle(4); pin = 0; idle(4); op(0, 1, A_STATUS, 0); idle(3);
      rsv = 1; idle(1); rsv = 0;
      op(1, 0, A_CTRL, 32'd1); idle(5);
      pin = 1; idle(2); op(1, 0, A_KICK, 0); pin = 0; idle(5);
      op(0, 1, A_STATUS, 0); op(1, 0, A_STATUS, 32'd1); op(0, 1, A_STATUS, 0);
      op(1, 0, A_TOCNT, 32'd5); op(0, 1, A_STATUS, 0); op(1, 0, A_STATUS, 32'd4); op(0, 1, A_STATUS, 0);
      op(0, 1, A_TOCNT, 0);
      op(1, 0, A_KICK, 0); idle(2); rsv = 1; idle(1); rsv = 0; op(0, 1, A_STATUS, 0); idle(1);
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 5) == 0) pin = ~pin;
         rsv = $urandom_range(0, 399) == 0;
         a = 2'($urandom_range(0, 3));
         dat = $urandom;
         if (a == A_CTRL) dat[0] = $urandom_range(0, 3) != 0;
         op(r < 25, r >= 15 && r < 60, a, dat);
      end
      rsv = 0; idle(4);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
